// File: rtl/ad9958_reg_writer_if.sv
// Command and serializer signal bundle for the AD9958 register writer.
// The master side issues commands and models the serializer; the slave side is the writer.
interface ad9958_reg_writer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [4:0]  cmd_addr;
  logic [31:0] cmd_data;
  logic        cmd_update;
  logic        spi_trigger;
  logic        spi_busy;
  logic [4:0]  spi_packs;
  logic [63:0] spi_data;
  logic        io_update;
  logic        done;
  logic        err;

  modport master (
    output cmd_valid, cmd_addr, cmd_data, cmd_update, spi_busy,
    input  cmd_ready, spi_trigger, spi_packs, spi_data, io_update, done, err
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_data, cmd_update, spi_busy,
    output cmd_ready, spi_trigger, spi_packs, spi_data, io_update, done, err
  );
endinterface

// File: rtl/ad9958_reg_writer.sv
// Turns a register write command into a nibble stream for a 4-bit SPI serializer,
// handshakes with the serializer, and optionally strobes IO_UPDATE afterwards.
module ad9958_reg_writer #(
  parameter int unsigned UPDATE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic               clock,
  input  logic               reset_n,
  ad9958_reg_writer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_TRIG    = 3'd1,
    S_WAIT_HI = 3'd2,
    S_WAIT_LO = 3'd3,
    S_UPDATE  = 3'd4
  } state_t;

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 32'd1);
  localparam logic [15:0] UPDATE_LAST  = 16'(UPDATE_CYCLES - 32'd1);

  // Data byte count per register address; zero marks an address that must not be written.
  function automatic logic [2:0] byte_count(input logic [4:0] addr);
    logic [2:0] n;
    case (addr)
      5'h00:   n = 3'd1;
      5'h01:   n = 3'd3;
      5'h02:   n = 3'd2;
      5'h03:   n = 3'd3;
      5'h04:   n = 3'd4;
      5'h05:   n = 3'd2;
      5'h06:   n = 3'd3;
      5'h07:   n = 3'd2;
      default: n = (addr <= 5'h18) ? 3'd4 : 3'd0;
    endcase
    return n;
  endfunction

  function automatic logic [7:0] nibble_swap(input logic [7:0] b);
    return {b[3:0], b[7:4]};
  endfunction

  // Left-aligning the N data bytes leaves the unsent low bytes zero, which keeps the
  // stream clear above 4*spi_packs without a separate mask.
  function automatic logic [63:0] build_stream(input logic [4:0] addr,
                                               input logic [31:0] data,
                                               input logic [2:0] nbytes);
    logic [31:0] aligned;
    logic [7:0]  instr;
    aligned = data << {3'd4 - nbytes, 3'b000};
    instr   = {1'b0, 2'b00, addr};
    return {24'd0,
            nibble_swap(aligned[7:0]),
            nibble_swap(aligned[15:8]),
            nibble_swap(aligned[23:16]),
            nibble_swap(aligned[31:24]),
            nibble_swap(instr)};
  endfunction

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [63:0] spi_data_q, spi_data_d;
  logic [4:0]  spi_packs_q, spi_packs_d;
  logic        upd_flag_q, upd_flag_d;
  logic        spi_trigger_q, spi_trigger_d;
  logic        io_update_q, io_update_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        cmd_ready_q, cmd_ready_d;

  logic [2:0]  nbytes_s;
  logic        addr_ok_s;
  logic        accept_s;
  logic        timeout_s;

  assign nbytes_s  = byte_count(bus.cmd_addr);
  assign addr_ok_s = (nbytes_s != 3'd0);
  assign accept_s  = (state_q == S_IDLE) && cmd_ready_q && bus.cmd_valid;
  assign timeout_s = (cnt_q == TIMEOUT_LAST);

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= 16'd0;
      spi_data_q    <= 64'd0;
      spi_packs_q   <= 5'd0;
      upd_flag_q    <= 1'b0;
      spi_trigger_q <= 1'b0;
      io_update_q   <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      cmd_ready_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      spi_data_q    <= spi_data_d;
      spi_packs_q   <= spi_packs_d;
      upd_flag_q    <= upd_flag_d;
      spi_trigger_q <= spi_trigger_d;
      io_update_q   <= io_update_d;
      done_q        <= done_d;
      err_q         <= err_d;
      cmd_ready_q   <= cmd_ready_d;
    end
  end

  // Next-state logic; busy edges take priority over the watchdog on the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s && addr_ok_s) begin
          state_d = S_TRIG;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_TRIG: begin
        state_d = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (bus.spi_busy) begin
          state_d = S_WAIT_LO;
        end else if (timeout_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT_HI;
        end
      end
      S_WAIT_LO: begin
        if (!bus.spi_busy) begin
          state_d = upd_flag_q ? S_UPDATE : S_IDLE;
        end else if (timeout_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT_LO;
        end
      end
      S_UPDATE: begin
        if (cnt_q == UPDATE_LAST) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_UPDATE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Next values of the registered outputs, derived from the upcoming state.
  always_comb begin
    if ((state_d != state_q) || (state_q == S_IDLE)) begin
      cnt_d = 16'd0;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end

    if (accept_s && addr_ok_s) begin
      spi_data_d  = build_stream(bus.cmd_addr, bus.cmd_data, nbytes_s);
      spi_packs_d = 5'd2 + {1'b0, nbytes_s, 1'b0};
      upd_flag_d  = bus.cmd_update;
    end else begin
      spi_data_d  = spi_data_q;
      spi_packs_d = spi_packs_q;
      upd_flag_d  = upd_flag_q;
    end

    spi_trigger_d = (state_d == S_TRIG) || (state_d == S_WAIT_HI);
    io_update_d   = (state_d == S_UPDATE);

    // With update, done lands on the final io_update cycle rather than after it.
    done_d = ((state_q == S_WAIT_LO) && !bus.spi_busy && !upd_flag_q) ||
             ((state_d == S_UPDATE) && (cnt_d == UPDATE_LAST));

    err_d = (accept_s && !addr_ok_s) ||
            ((state_q == S_WAIT_HI) && !bus.spi_busy && timeout_s) ||
            ((state_q == S_WAIT_LO) && bus.spi_busy && timeout_s);

    cmd_ready_d = (state_d == S_IDLE) && !done_d && !err_d;
  end

  assign bus.cmd_ready   = cmd_ready_q & reset_n;
  assign bus.spi_trigger = spi_trigger_q;
  assign bus.spi_packs   = spi_packs_q;
  assign bus.spi_data    = spi_data_q;
  assign bus.io_update   = io_update_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;

endmodule

// File: doc/ad9958_reg_writer.md
AD9958_REG_WRITER -- requirements
Module: ad9958_reg_writer

Interface
REQ-001 The block SHALL have parameter UPDATE_CYCLES, default 4, which is the io_update pulse width in clock cycles (legal range 1-255).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 1024, which is the maximum number of cycles allowed in each SPI wait state (legal range 2-65535).
REQ-003 clock  input  1  system clock; all logic on posedge.
REQ-004 reset_n  input  1  reset, synchronous, active-low.
REQ-005 cmd_valid  input  1  write command present.
REQ-006 cmd_ready  output  1  block accepts a command this cycle.
REQ-007 cmd_addr  input  5  AD9958 register address.
REQ-008 cmd_data  input  32  register value, right-justified.
REQ-009 cmd_update  input  1  issue io_update after the write.
REQ-010 spi_trigger  output  1  start request to the 4-bit SPI serializer.
REQ-011 spi_busy  input  1  serializer busy.
REQ-012 spi_packs  output  5  number of nibbles to send.
REQ-013 spi_data  output  64  nibble stream; nibble k is at bits [4k+3:4k] and nibble 0 is sent first.
REQ-014 io_update  output  1  AD9958 IO_UPDATE strobe.
REQ-015 done  output  1  one-cycle pulse when a command completes.
REQ-016 err  output  1  one-cycle pulse when a command is rejected (bad address) or times out.

Function
REQ-017 Register byte count SHALL be: 0x00->1; 0x01->3; 0x02->2; 0x03->3; 0x04->4; 0x05->2; 0x06->3; 0x07->2; 0x08..0x18->4; 0x19..0x1F invalid.
REQ-018 Instruction byte SHALL be {1'b0 (write), 2'b00, cmd_addr}.
REQ-019 Nibble order SHALL be: instruction[7:4], then instruction[3:0], then the data bytes MSB byte first, high nibble first; only the low N bytes of cmd_data are sent.
REQ-020 spi_packs SHALL equal 2+2N, where N is the byte count; spi_data bits at and above 4*spi_packs SHALL be zero.
REQ-021 States SHALL be IDLE, TRIG, WAIT_HI, WAIT_LO, UPDATE.
REQ-022 IDLE: cmd_ready=1; on cmd_valid a command is accepted, and spi_data, spi_packs and the update flag are registered.
REQ-023 A command with an invalid address SHALL NOT be sent; err pulses the next cycle and the block stays in IDLE.
REQ-024 IDLE -> TRIG on accepting a valid address; spi_trigger=1 throughout TRIG.
REQ-025 TRIG -> WAIT_HI on the cycle after entry; spi_trigger stays 1 in WAIT_HI until spi_busy=1 is sampled.
REQ-026 WAIT_HI -> WAIT_LO when spi_busy=1 is sampled; spi_trigger deasserts in the same cycle.
REQ-027 WAIT_LO -> UPDATE when spi_busy=0 is sampled and the update flag is set; otherwise WAIT_LO -> IDLE with done pulsed.
REQ-028 UPDATE: io_update=1 for exactly UPDATE_CYCLES cycles, then -> IDLE with done pulsed on the transition cycle.
REQ-029 cmd_ready SHALL be 0 in every state except IDLE; cmd_* inputs are ignored outside IDLE.
REQ-030 spi_data and spi_packs SHALL remain stable from acceptance until the block returns to IDLE.
REQ-031 A watchdog counter SHALL restart on entry to WAIT_HI and on entry to WAIT_LO; reaching TIMEOUT_CYCLES in either state -> IDLE with err pulsed, spi_trigger=0, and no io_update.
REQ-032 done and err SHALL never assert in the same cycle.
REQ-033 Back-to-back commands SHALL be supported; cmd_ready returns to 1 in the cycle after done or err.

Reset
REQ-034 When reset_n=0 at a posedge: state=IDLE; spi_trigger, io_update, done and err = 0; spi_data=0; spi_packs=0; counters=0.
REQ-035 While reset_n=0, cmd_ready SHALL be 0.
REQ-036 Reset mid-operation SHALL abort immediately, with no done or err pulse for the aborted command.

Verification
REQ-037 Write addr 0x04, data 0x12345678, update=0; model busy for 20 cycles -> spi_packs=10, spi_data=0x0000_0087_6543_2140, nibbles sent in order 0,4,1,2,3,4,5,6,7,8; done pulses once; io_update never asserts.
REQ-038 Write addr 0x00, data 0xF0, update=1 -> spi_packs=4, spi_data low 16 bits=0x0F00; io_update high for 4 cycles after busy falls; done pulses on the last cycle.
REQ-039 Write addr 0x1A -> no spi_trigger; err pulses once; cmd_ready=1 two cycles later.
REQ-040 Hold spi_busy=0 after trigger (TIMEOUT_CYCLES=16) -> err after 16 cycles in WAIT_HI; spi_trigger drops; no done.
REQ-041 Assert reset_n=0 during WAIT_LO -> all outputs at reset values next cycle; a following addr 0x02 write gives spi_packs=6.
REQ-042 Three back-to-back commands with cmd_valid held high -> each accepted only in IDLE; three done pulses; spi_data is never changed while busy.
